// File: rtl/axis_backpressure_sink.sv
`default_nettype none
// ---------------------------------------------------------------------------
// axis_backpressure_sink: AXI4-Stream sink with programmable back-pressure,
// saturating traffic statistics and a sticky payload-stability checker. Rev 1.0
// ---------------------------------------------------------------------------
module axis_backpressure_sink #(
  parameter int          T_DATA_WIDTH = 64,
  parameter int          T_USER_WIDTH = 4,
  parameter int          CNT_WIDTH    = 32,
  parameter logic [31:0] LFSR_SEED    = 32'hACE12468
) (
  input  logic                      aclk,
  input  logic                      areset_n,
  input  logic [1:0]                cfg_mode,
  input  logic [15:0]               cfg_gap,
  input  logic [15:0]               cfg_rand_min,
  input  logic [15:0]               cfg_rand_max,
  input  logic [7:0]                cfg_stall_pct,
  input  logic                      s_tvalid,
  output logic                      s_tready,
  input  logic [T_DATA_WIDTH-1:0]   s_tdata,
  input  logic [T_DATA_WIDTH/8-1:0] s_tstrb,
  input  logic                      s_tlast,
  input  logic [T_USER_WIDTH-1:0]   s_tuser,
  input  logic                      stat_clear,
  output logic [CNT_WIDTH-1:0]      stat_beats,
  output logic [CNT_WIDTH-1:0]      stat_packets,
  output logic [CNT_WIDTH-1:0]      stat_stall_cycles,
  output logic                      err_stable,
  input  logic                      err_clear
);

  localparam int          STRB_WIDTH    = T_DATA_WIDTH / 8;
  localparam int          PAYLOAD_WIDTH = T_DATA_WIDTH + STRB_WIDTH + 1 + T_USER_WIDTH;
  localparam logic [31:0] LFSR_POLY     = 32'h80200003;
  localparam logic [1:0]  MODE_ALWAYS   = 2'd0;
  localparam logic [1:0]  MODE_STATIC   = 2'd1;
  localparam logic [1:0]  MODE_STALL    = 2'd3;

  typedef enum logic [1:0] {
    READY = 2'd0,
    GAP   = 2'd1,
    STALL = 2'd2
  } state_t;

  state_t      state, state_next;
  logic [15:0] cnt, cnt_next;
  logic        ready;
  logic [31:0] lfsr;
  logic        hs, last_hs;

  logic [16:0] span;
  logic [31:0] prod;
  logic [15:0] rand_off, rand_gap, gap_len;

  assign s_tready = ready;
  assign hs       = s_tvalid & ready;
  assign last_hs  = hs & s_tlast;

  always_ff @(posedge aclk) begin
    if (!areset_n) begin
      lfsr <= LFSR_SEED;
    end else begin
      lfsr <= (lfsr >> 1) ^ (lfsr[0] ? LFSR_POLY : 32'd0);
    end
  end

  // Scale the low LFSR half into [0, span) with a fixed-point multiply.
  always_comb begin
    span     = {1'b0, cfg_rand_max} - {1'b0, cfg_rand_min} + 17'd1;
    prod     = {16'd0, lfsr[15:0]} * {15'd0, span};
    rand_off = 16'(prod >> 16);
    if (cfg_rand_max <= cfg_rand_min) begin
      rand_gap = cfg_rand_min;
    end else begin
      rand_gap = cfg_rand_min + rand_off;
    end
    case (cfg_mode)
      MODE_ALWAYS: gap_len = 16'd0;
      MODE_STATIC: gap_len = cfg_gap;
      default:     gap_len = rand_gap;
    endcase
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      READY: begin
        if (last_hs) begin
          if (gap_len != 16'd0) begin
            state_next = GAP;
            cnt_next   = gap_len - 16'd1;
          end
        end else if ((cfg_mode == MODE_STALL) && s_tvalid &&
                     (lfsr[23:16] < cfg_stall_pct)) begin
          state_next = STALL;
        end
      end
      GAP: begin
        if (cnt == 16'd0) begin
          state_next = READY;
        end else begin
          cnt_next = cnt - 16'd1;
        end
      end
      STALL:   state_next = READY;
      default: state_next = READY;
    endcase
  end

  // Reset parks the FSM in an expired gap so ready rises on the first active edge.
  always_ff @(posedge aclk) begin
    if (!areset_n) begin
      state <= GAP;
      cnt   <= 16'd0;
      ready <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      ready <= (state_next == READY);
    end
  end

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v,
                                                   input logic                 en);
    return (en && (v != '1)) ? v + CNT_WIDTH'(1) : v;
  endfunction

  always_ff @(posedge aclk) begin
    if (!areset_n || stat_clear) begin
      stat_beats        <= '0;
      stat_packets      <= '0;
      stat_stall_cycles <= '0;
    end else begin
      stat_beats        <= sat_inc(stat_beats, hs);
      stat_packets      <= sat_inc(stat_packets, last_hs);
      stat_stall_cycles <= sat_inc(stat_stall_cycles, s_tvalid & ~ready);
    end
  end

  logic [PAYLOAD_WIDTH-1:0] payload, payload_prev;
  logic                     stalled_prev, stable_err;

  assign payload    = {s_tdata, s_tstrb, s_tlast, s_tuser};
  assign stable_err = stalled_prev & (~s_tvalid | (payload != payload_prev));

  always_ff @(posedge aclk) begin
    if (!areset_n) begin
      stalled_prev <= 1'b0;
      payload_prev <= '0;
      err_stable   <= 1'b0;
    end else begin
      stalled_prev <= s_tvalid & ~ready;
      payload_prev <= payload;
      if (stable_err) begin
        err_stable <= 1'b1;
      end else if (err_clear) begin
        err_stable <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axis_backpressure_sink.sv
`default_nettype none
// Bench for axis_backpressure_sink: cycle model of ready/stats/error plus directed scenarios.
module tb_axis_backpressure_sink;

  localparam int          DW   = 64;
  localparam int          UW   = 4;
  localparam int          CW   = 8;
  localparam int          CMAX = 255;
  localparam logic [31:0] SEED = 32'hACE12468;

  logic          aclk = 1'b0;
  logic          areset_n = 1'b0;
  logic [1:0]    cfg_mode = 2'd0;
  logic [15:0]   cfg_gap = 16'd0, cfg_rand_min = 16'd0, cfg_rand_max = 16'd0;
  logic [7:0]    cfg_stall_pct = 8'd0;
  logic          s_tvalid = 1'b0, s_tready;
  logic [DW-1:0] s_tdata = '0;
  logic [7:0]    s_tstrb = '0;
  logic          s_tlast = 1'b0;
  logic [UW-1:0] s_tuser = '0;
  logic          stat_clear = 1'b0, err_clear = 1'b0, err_stable;
  logic [CW-1:0] stat_beats, stat_packets, stat_stall_cycles;

  axis_backpressure_sink #(
    .T_DATA_WIDTH(DW), .T_USER_WIDTH(UW), .CNT_WIDTH(CW), .LFSR_SEED(SEED)
  ) dut (
    .aclk(aclk), .areset_n(areset_n), .cfg_mode(cfg_mode), .cfg_gap(cfg_gap),
    .cfg_rand_min(cfg_rand_min), .cfg_rand_max(cfg_rand_max), .cfg_stall_pct(cfg_stall_pct),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tstrb(s_tstrb),
    .s_tlast(s_tlast), .s_tuser(s_tuser), .stat_clear(stat_clear),
    .stat_beats(stat_beats), .stat_packets(stat_packets),
    .stat_stall_cycles(stat_stall_cycles), .err_stable(err_stable), .err_clear(err_clear)
  );

  always #5 aclk = ~aclk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: ready is low while a countdown of blocked cycles is pending.
  bit          m_valid = 0, m_ready, m_err, m_prev_stall;
  int          m_rem, m_beats, m_pkts, m_stalls;
  bit [31:0]   m_lfsr;
  logic [76:0] m_prev_payload;

  function automatic bit [31:0] lfsr_step(input bit [31:0] l);
    return (l >> 1) ^ (l[0] ? 32'h80200003 : 32'd0);
  endfunction

  function automatic int rand_draw(input bit [31:0] l, input int lo, input int hi);
    longint scaled;
    if (hi <= lo) return lo;
    scaled = (longint'(l[15:0]) * longint'(hi - lo + 1)) >>> 16;
    return lo + int'(scaled);
  endfunction

  task automatic model_step();
    bit          hs, lhs;
    int          g;
    logic [76:0] cur;
    if (!areset_n) begin
      m_ready = 0; m_rem = 0; m_lfsr = SEED; m_err = 0;
      m_beats = 0; m_pkts = 0; m_stalls = 0;
      m_prev_stall = 0; m_prev_payload = '0;
      return;
    end
    hs  = s_tvalid && m_ready;
    lhs = hs && s_tlast;
    if (stat_clear) begin
      m_beats = 0; m_pkts = 0; m_stalls = 0;
    end else begin
      if (hs && m_beats < CMAX) m_beats++;
      if (lhs && m_pkts < CMAX) m_pkts++;
      if (s_tvalid && !m_ready && m_stalls < CMAX) m_stalls++;
    end
    cur = {s_tdata, s_tstrb, s_tlast, s_tuser};
    if (m_prev_stall && (!s_tvalid || cur != m_prev_payload)) m_err = 1;
    else if (err_clear) m_err = 0;
    m_prev_stall   = s_tvalid && !m_ready;
    m_prev_payload = cur;
    if (m_ready && lhs) begin
      case (cfg_mode)
        2'd0:    g = 0;
        2'd1:    g = int'(cfg_gap);
        default: g = rand_draw(m_lfsr, int'(cfg_rand_min), int'(cfg_rand_max));
      endcase
      m_rem = g;
    end else if (m_ready && cfg_mode == 2'd3 && s_tvalid && m_lfsr[23:16] < cfg_stall_pct) begin
      m_rem = 1;
    end
    if (m_rem > 0) begin
      m_ready = 0;
      m_rem--;
    end else begin
      m_ready = 1;
    end
    m_lfsr = lfsr_step(m_lfsr);
  endtask

  // Compare DUT against the model's view of this cycle, then advance the model
  // with the inputs the next active edge will sample.
  initial begin
    forever begin
      @(negedge aclk);
      if (m_valid) begin
        chk("s_tready", s_tready, m_ready);
        chk("stat_beats", stat_beats, m_beats);
        chk("stat_packets", stat_packets, m_pkts);
        chk("stat_stall_cycles", stat_stall_cycles, m_stalls);
        chk("err_stable", err_stable, m_err);
      end
      model_step();
      m_valid = 1;
    end
  end

  // Lengths of each run of ready-low cycles outside reset.
  int run_len = 0;
  int gaps[$];
  initial begin
    forever begin
      @(negedge aclk);
      if (!areset_n) run_len = 0;
      else if (s_tready !== 1'b1) run_len++;
      else if (run_len > 0) begin
        gaps.push_back(run_len);
        run_len = 0;
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge aclk);
      #1;
    end
  endtask

  task automatic send_beat(input logic [63:0] d, input logic last);
    bit taken = 0;
    int waited = 0;
    s_tvalid = 1'b1; s_tdata = d; s_tstrb = 8'hFF; s_tlast = last; s_tuser = d[3:0];
    while (!taken && waited < 200) begin
      @(negedge aclk);
      taken = (s_tready === 1'b1);
      @(posedge aclk);
      #1;
      waited++;
    end
    if (!taken) chk("beat_timeout", 64'd0, 64'd1);
  endtask

  task automatic send_pkt(input int n, input logic [63:0] base);
    for (int i = 0; i < n; i++) send_beat(base + 64'(i), (i == n - 1));
  endtask

  task automatic idle();
    s_tvalid = 1'b0; s_tlast = 1'b0;
  endtask

  task automatic pulse_stat_clear();
    stat_clear = 1'b1; tick(); stat_clear = 1'b0;
  endtask

  task automatic do_reset();
    areset_n = 1'b0;
    tick(2);
    chk("rst_tready", s_tready, 1'b0);
    chk("rst_beats", stat_beats, 0);
    chk("rst_err", err_stable, 1'b0);
    areset_n = 1'b1;
    tick();
    chk("rel_tready", s_tready, 1'b1);
    chk("rel_stalls", stat_stall_cycles, 0);
    chk("rel_packets", stat_packets, 0);
    chk("model_lfsr_pin", m_lfsr, 32'h56709234);
    tick();
    gaps.delete();
  endtask

  int seq1[$];
  int diff, bad;

  initial begin
    do_reset();

    // Always-ready: three 4-beat packets, then a long packet to saturate the beat counter.
    cfg_mode = 2'd0;
    for (int p = 0; p < 3; p++) send_pkt(4, 64'(p * 16));
    idle(); tick();
    chk("m0_beats", stat_beats, 12);
    chk("m0_packets", stat_packets, 3);
    chk("m0_stalls", stat_stall_cycles, 0);
    chk("m0_no_gaps", gaps.size(), 0);
    pulse_stat_clear();
    send_pkt(300, 64'h1000);
    idle(); tick();
    chk("sat_beats", stat_beats, 255);
    chk("sat_packets", stat_packets, 1);

    // Static gap of 5 between back-to-back packets, then a zero gap.
    cfg_mode = 2'd1; cfg_gap = 16'd5;
    pulse_stat_clear(); gaps.delete();
    send_pkt(4, 64'h2000); send_pkt(4, 64'h2100);
    idle(); tick(10);
    chk("m1_gap_count", gaps.size(), 2);
    if (gaps.size() == 2) begin
      chk("m1_gap0", gaps[0], 5);
      chk("m1_gap1", gaps[1], 5);
    end
    chk("m1_stalls", stat_stall_cycles, 5);
    chk("m1_beats", stat_beats, 8);
    cfg_gap = 16'd0;
    pulse_stat_clear(); gaps.delete();
    send_pkt(4, 64'h2200); send_pkt(4, 64'h2300);
    idle(); tick(3);
    chk("m1_zero_gaps", gaps.size(), 0);
    chk("m1_zero_stalls", stat_stall_cycles, 0);

    // Random gap in [3,7]; repeating from reset must reproduce the sequence.
    cfg_mode = 2'd2; cfg_rand_min = 16'd3; cfg_rand_max = 16'd7;
    for (int run = 0; run < 2; run++) begin
      do_reset();
      for (int p = 0; p < 200; p++) send_pkt(1, 64'(p));
      idle(); tick(10);
      chk("m2_gap_count", gaps.size(), 200);
      bad = 0;
      foreach (gaps[i]) if (gaps[i] < 3 || gaps[i] > 7) bad++;
      chk("m2_gap_range", bad, 0);
      if (run == 0) seq1 = gaps;
    end
    diff = (seq1.size() == gaps.size()) ? 0 : 1;
    foreach (seq1[i]) if (i < gaps.size() && seq1[i] != gaps[i]) diff++;
    chk("m2_gap_repeat", diff, 0);
    cfg_rand_min = 16'd9; cfg_rand_max = 16'd4;
    gaps.delete();
    for (int p = 0; p < 20; p++) send_pkt(1, 64'(p));
    idle(); tick(12);
    chk("m2_inv_count", gaps.size(), 20);
    bad = 0;
    foreach (gaps[i]) if (gaps[i] != 9) bad++;
    chk("m2_inv_all9", bad, 0);

    // Random in-packet stalls, no inter-packet gap.
    cfg_mode = 2'd3; cfg_stall_pct = 8'd255; cfg_rand_min = 16'd0; cfg_rand_max = 16'd0;
    pulse_stat_clear(); gaps.delete();
    send_pkt(8, 64'h3000);
    idle(); tick(3);
    chk("m3_beats", stat_beats, 8);
    chk("m3_packets", stat_packets, 1);
    chk("m3_stalled", (stat_stall_cycles > 0), 1'b1);
    bad = 0;
    foreach (gaps[i]) if (gaps[i] != 1) bad++;
    chk("m3_single_cycle", bad, 0);

    // Payload stability checker.
    cfg_mode = 2'd1; cfg_gap = 16'd6; cfg_stall_pct = 8'd0;
    send_pkt(1, 64'h4000);
    s_tvalid = 1'b1; s_tdata = 64'hA; s_tlast = 1'b1;
    tick(2);
    chk("err_quiet", err_stable, 1'b0);
    s_tdata = 64'hB;
    tick();
    chk("err_set", err_stable, 1'b1);
    tick(2);
    chk("err_sticky", err_stable, 1'b1);
    send_beat(64'hB, 1'b1);
    idle(); tick(8);
    err_clear = 1'b1; tick(); err_clear = 1'b0;
    chk("err_cleared", err_stable, 1'b0);
    send_pkt(1, 64'h4100);
    s_tvalid = 1'b1; s_tdata = 64'hC; s_tlast = 1'b1;
    tick(2);
    s_tdata = 64'hD; err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    chk("err_beats_clear", err_stable, 1'b1);
    send_beat(64'hD, 1'b1);
    idle(); tick(8);
    err_clear = 1'b1; tick(); err_clear = 1'b0;
    send_pkt(1, 64'h4200);
    s_tvalid = 1'b1; s_tdata = 64'hE;
    tick();
    idle();
    tick();
    chk("err_valid_drop", err_stable, 1'b1);
    tick(8);
    pulse_stat_clear();
    chk("clr_beats", stat_beats, 0);
    chk("clr_packets", stat_packets, 0);
    chk("clr_stalls", stat_stall_cycles, 0);

    // Reset in the middle of a 10-cycle gap.
    cfg_gap = 16'd10;
    send_pkt(1, 64'h5000);
    idle(); tick(3);
    chk("gap_running", s_tready, 1'b0);
    do_reset();
    chk("post_rst_beats", stat_beats, 0);
    tick(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
